// File: rtl/uart_tx_drain.sv
// UART transmitter draining bytes from a FIFO read port over valid/ready.
// Frames are start + 8 data bits (LSB first) + optional even parity + 1..2 stop bits.
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       out_clk,
  input  logic       reset,
  input  logic [7:0] in_d,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BC_W = 16;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [2:0]      bi_q, bi_d;
  logic            stop_q, stop_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    bi_d       = bi_q;
    stop_d     = stop_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = tx_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;

    if (state_q == S_IDLE) begin
      tx_d       = 1'b1;
      in_ready_d = 1'b1;
      busy_d     = 1'b0;
      if (in_valid && in_ready_q) begin
        shreg_d    = in_d;
        par_d      = ^in_d;
        tx_d       = 1'b0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        bc_d       = '0;
        state_d    = S_START;
      end
    end else if (bc_q != BC_LAST) begin
      bc_d = bc_q + BC_W'(1);
    end else begin
      // Bit boundary: advance state and present the next bit on tx.
      bc_d = '0;
      unique case (state_q)
        S_START: begin
          state_d = S_DATA;
          bi_d    = 3'd0;
          tx_d    = shreg_q[0];
        end
        S_DATA: begin
          if (bi_q != 3'd7) begin
            bi_d = bi_q + 3'd1;
            tx_d = shreg_q[3'(bi_q + 3'd1)];
          end else if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          if (stop_q == STOP_LAST) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            tx_d       = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge out_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bc_q       <= '0;
      bi_q       <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      bi_q       <= bi_d;
      stop_q     <= stop_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: four parameterisations checked against an
// expected-bit-sequence model built from the frame format.
module tb_uart_tx_drain;

  logic       clk;
  logic       rst_n;
  logic [3:0] vld;
  logic [7:0] d [4];
  logic [3:0] rdy_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;

  int n_assert = 0;
  int n_fail   = 0;
  int hs   [4] = '{0, 0, 0, 0};
  int exp_hs [4] = '{0, 0, 0, 0};

  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .out_clk(clk), .reset(rst_n), .in_d(d[0]), .in_valid(vld[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_b (
    .out_clk(clk), .reset(rst_n), .in_d(d[1]), .in_valid(vld[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx_drain #(.CLKS_PER_BIT(3), .PARITY_EN(0), .STOP_BITS(2)) u_c (
    .out_clk(clk), .reset(rst_n), .in_d(d[2]), .in_valid(vld[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx_drain #(.CLKS_PER_BIT(5), .PARITY_EN(1), .STOP_BITS(2)) u_d (
    .out_clk(clk), .reset(rst_n), .in_d(d[3]), .in_valid(vld[3]),
    .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every handshake each instance actually sees.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (rst_n && vld[k] && rdy_w[k]) hs[k] = hs[k] + 1;
  end

  function automatic int cpb_of(input int i);
    case (i)
      2: return 3;
      3: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int par_of(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int i);
    return (i >= 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with vld[i]/d[i] already presenting byte b.
  // mode 0: drop valid after acceptance; 1: random valid/data mid-frame;
  // 2: keep valid high with nxt queued for a back-to-back frame.
  task automatic run_frame(input int i, input logic [7:0] b, input int mode,
                           input logic [7:0] nxt, output time t_acc);
    logic bits[$];
    int   cpb;
    int   nbits;
    cpb = cpb_of(i);
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    if (par_of(i) != 0) bits.push_back(^b);
    for (int j = 0; j < stop_of(i); j++) bits.push_back(1'b1);
    nbits = bits.size();
    chk($sformatf("ready_before_accept[%0d]", i), 32'(rdy_w[i]), 32'd1);
    @(posedge clk);
    t_acc = $time;
    exp_hs[i]++;
    @(negedge clk);
    if (mode == 2) d[i] = nxt;
    else begin
      vld[i] = 1'b0;
      d[i]   = 8'($urandom);
    end
    for (int c = 0; c < nbits * cpb; c++) begin
      chk($sformatf("tx[%0d] byte %02h cyc %0d", i, b, c), 32'(tx_w[i]), 32'(bits[c / cpb]));
      chk($sformatf("busy[%0d] cyc %0d", i, c), 32'(busy_w[i]), 32'd1);
      chk($sformatf("ready_mid[%0d] cyc %0d", i, c), 32'(rdy_w[i]), 32'd0);
      if (mode == 1) begin
        vld[i] = 1'($urandom);
        d[i]   = 8'($urandom);
      end
      @(negedge clk);
    end
    chk($sformatf("tx_idle[%0d]", i), 32'(tx_w[i]), 32'd1);
    chk($sformatf("busy_end[%0d]", i), 32'(busy_w[i]), 32'd0);
    chk($sformatf("ready_end[%0d]", i), 32'(rdy_w[i]), 32'd1);
    if (mode != 2) vld[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] b, input int mode);
    time t;
    d[i]   = b;
    vld[i] = 1'b1;
    run_frame(i, b, mode, 8'h00, t);
  endtask

  initial begin
    time        t1, t2;
    logic [7:0] rb;
    rst_n = 1'b0;
    vld   = '0;
    for (int k = 0; k < 4; k++) d[k] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tx[%0d]", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy_w[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ready_after_release[%0d]", k), 32'(rdy_w[k]), 32'd1);

    // Single frame, parity frames
    send(0, 8'hA5, 0);
    send(1, 8'h01, 0);
    send(1, 8'hA5, 0);

    // Back-to-back 0x00 then 0xFF
    d[0]   = 8'h00;
    vld[0] = 1'b1;
    run_frame(0, 8'h00, 2, 8'hFF, t1);
    run_frame(0, 8'hFF, 0, 8'h00, t2);
    chk("b2b_period", 32'((t2 - t1) / 10), 32'd41);

    // Two stop bits with random mid-frame valid/data activity
    for (int n = 0; n < 3; n++) send(2, 8'($urandom), 1);

    // Random bytes on the parity + two-stop configuration
    for (int n = 0; n < 4; n++) send(3, 8'($urandom), n % 2);
    for (int n = 0; n < 3; n++) send(1, 8'($urandom), 1);

    // Reset during data bit 3
    rb     = 8'($urandom);
    d[0]   = rb;
    vld[0] = 1'b1;
    @(posedge clk);
    exp_hs[0]++;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_bit3_value", 32'(tx_w[0]), 32'(rb[3]));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_ready", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h3C, 0);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("handshakes[%0d]", k), 32'(hs[k]), 32'(exp_hs[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
